// File: rtl/rename_ctrl_pkg.sv
// Shared types and sizing helpers for the rename dispatch controller.
// Optional build macro RENAME_BYPASS_EN is consumed by the files that import this package.
package rename_ctrl_pkg;

    localparam int ARCH_W  = 5;
    localparam int STALL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RENAME = 2'd1,
        ST_STALL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [ARCH_W-1:0] rs1;
        logic [ARCH_W-1:0] rs2;
        logic [ARCH_W-1:0] rd;
        logic              valid;
    } lane_t;

    function automatic int phys_w(input int phys_regs);
        return $clog2(phys_regs);
    endfunction

endpackage

// File: rtl/rename_slice_select.sv
// Picks the in-order slice of pending lanes that fits the free list and has no intra-slice hazard.
// With RENAME_BYPASS_EN defined the hazard cut is skipped (the top forwards operands instead).
module rename_slice_select
    import rename_ctrl_pkg::*;
#(
    parameter int ISSUE_WIDTH = 4,
    parameter int PW          = 6
) (
    input  logic [ISSUE_WIDTH-1:0]        pending_i,
    input  logic [ISSUE_WIDTH*ARCH_W-1:0] rd_i,
    input  logic [ISSUE_WIDTH*ARCH_W-1:0] rs1_i,
    input  logic [ISSUE_WIDTH*ARCH_W-1:0] rs2_i,
    input  logic [PW:0]                   free_count_i,
    output logic [ISSUE_WIDTH-1:0]        slice_o,
    output logic [PW:0]                   alloc_cnt_o
);

    logic              stop;
    logic              dep;
    logic              need;
    logic [ARCH_W-1:0] rd_j;
    logic [ARCH_W-1:0] rs1_j;
    logic [ARCH_W-1:0] rs2_j;
`ifndef RENAME_BYPASS_EN
    logic [ARCH_W-1:0] rd_k;
`endif

    always_comb begin
        slice_o     = '0;
        alloc_cnt_o = '0;
        stop        = 1'b0;
        dep         = 1'b0;
        need        = 1'b0;
        rd_j        = '0;
        rs1_j       = '0;
        rs2_j       = '0;
`ifndef RENAME_BYPASS_EN
        rd_k        = '0;
`endif
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            rd_j  = rd_i[j*ARCH_W +: ARCH_W];
            rs1_j = rs1_i[j*ARCH_W +: ARCH_W];
            rs2_j = rs2_i[j*ARCH_W +: ARCH_W];
            need  = (rd_j != '0);
            dep   = 1'b0;
`ifndef RENAME_BYPASS_EN
            // A nonzero rd already in the slice makes equality imply a nonzero source.
            for (int k = 0; k < j; k++) begin
                rd_k = rd_i[k*ARCH_W +: ARCH_W];
                if (slice_o[k] && rd_k != '0 &&
                    (rs1_j == rd_k || rs2_j == rd_k || rd_j == rd_k)) begin
                    dep = 1'b1;
                end
            end
`endif
            if (pending_i[j] && !stop) begin
                if (dep || ((alloc_cnt_o + {{PW{1'b0}}, need}) > free_count_i)) begin
                    stop = 1'b1;
                end else begin
                    slice_o[j]  = 1'b1;
                    alloc_cnt_o = alloc_cnt_o + {{PW{1'b0}}, need};
                end
            end
        end
    end

endmodule

// File: rtl/rename_dispatch_ctrl.sv
// Sequencer between decode and register_rename_table: slices groups, owns stalls, flush and dispatch output.
// Build macro RENAME_BYPASS_EN: keep dependent lanes in one slice and forward phys_rd within it.
module rename_dispatch_ctrl
    import rename_ctrl_pkg::*;
#(
    parameter int ISSUE_WIDTH = 4,
    parameter int PHYS_REGS   = 64,
    parameter int ARCH_REGS   = 32,
    localparam int PW         = phys_w(PHYS_REGS),
    localparam int AW         = $clog2(ARCH_REGS),
    localparam int IW         = ISSUE_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 grp_valid_i,
    output logic                 grp_ready_o,
    input  logic [IW-1:0]        grp_lane_valid_i,
    input  logic [IW*AW-1:0]     grp_rs1_i,
    input  logic [IW*AW-1:0]     grp_rs2_i,
    input  logic [IW*AW-1:0]     grp_rd_i,
    output logic [IW-1:0]        rt_rename_valid_o,
    output logic [IW*AW-1:0]     rt_arch_rs1_o,
    output logic [IW*AW-1:0]     rt_arch_rs2_o,
    output logic [IW*AW-1:0]     rt_arch_rd_o,
    input  logic [IW-1:0]        rt_rename_ready_i,
    input  logic [IW*PW-1:0]     rt_phys_rs1_i,
    input  logic [IW*PW-1:0]     rt_phys_rs2_i,
    input  logic [IW*PW-1:0]     rt_phys_rd_i,
    input  logic [IW*PW-1:0]     rt_old_phys_rd_i,
    input  logic [PW:0]          rt_free_count_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [IW-1:0]        out_lane_valid_o,
    output logic [IW*PW-1:0]     out_phys_rs1_o,
    output logic [IW*PW-1:0]     out_phys_rs2_o,
    output logic [IW*PW-1:0]     out_phys_rd_o,
    output logic [IW*PW-1:0]     out_old_phys_rd_o,
    output logic [STALL_W-1:0]   stall_cycles_o
);

    state_e               state_q, state_d;
    lane_t                lane_q [IW];
    lane_t                lane_d [IW];
    logic                 out_valid_q;
    logic [IW-1:0]        out_lane_q;
    logic [IW*PW-1:0]     out_rs1_q, out_rs2_q, out_rd_q, out_old_q;
    logic [IW*PW-1:0]     nxt_rs1, nxt_rs2, nxt_rd, nxt_old;
    logic [STALL_W-1:0]   stall_q;

    logic [IW-1:0]        pending;
    logic [IW-1:0]        slice_mask;
    logic [PW:0]          alloc_cnt;
    logic                 lowest_alloc;
    logic                 found;
    logic                 free_zero;
    logic                 out_free;
    logic                 can_req;
    logic                 issue;
    logic                 stall_inc;

    // Handshake: a transfer happens on a cycle where valid && ready; valid never depends on ready.
    assign grp_ready_o       = (state_q == ST_IDLE) && !flush_i;
    assign free_zero         = (rt_free_count_i == '0);
    assign out_free          = !out_valid_q || out_ready_i;
    assign can_req           = !flush_i && ((state_q == ST_RENAME) ||
                                            (state_q == ST_STALL && !free_zero));
    assign issue             = can_req && out_free && (slice_mask != '0);
    assign rt_rename_valid_o = issue ? slice_mask : '0;
    assign stall_inc         = (state_q == ST_STALL) || (state_q == ST_RENAME && !out_free);

    always_comb begin
        pending       = '0;
        rt_arch_rs1_o = '0;
        rt_arch_rs2_o = '0;
        rt_arch_rd_o  = '0;
        lowest_alloc  = 1'b0;
        found         = 1'b0;
        for (int i = 0; i < IW; i++) begin
            pending[i]              = lane_q[i].valid;
            rt_arch_rs1_o[i*AW +: AW] = lane_q[i].rs1;
            rt_arch_rs2_o[i*AW +: AW] = lane_q[i].rs2;
            rt_arch_rd_o[i*AW +: AW]  = lane_q[i].rd;
            if (lane_q[i].valid && !found) begin
                found        = 1'b1;
                lowest_alloc = (lane_q[i].rd != '0);
            end
        end
    end

    rename_slice_select #(
        .ISSUE_WIDTH (IW),
        .PW          (PW)
    ) u_slice (
        .pending_i    (pending),
        .rd_i         (rt_arch_rd_o),
        .rs1_i        (rt_arch_rs1_o),
        .rs2_i        (rt_arch_rs2_o),
        .free_count_i (rt_free_count_i),
        .slice_o      (slice_mask),
        .alloc_cnt_o  (alloc_cnt)
    );

    always_comb begin
        nxt_rs1 = rt_phys_rs1_i;
        nxt_rs2 = rt_phys_rs2_i;
        nxt_rd  = rt_phys_rd_i;
        nxt_old = rt_old_phys_rd_i;
`ifdef RENAME_BYPASS_EN
        // Ascending k lets the nearest earlier writer overwrite farther ones.
        for (int j = 1; j < IW; j++) begin
            for (int k = 0; k < j; k++) begin
                if (slice_mask[j] && slice_mask[k] && lane_q[k].rd != '0) begin
                    if (lane_q[j].rs1 == lane_q[k].rd) nxt_rs1[j*PW +: PW] = rt_phys_rd_i[k*PW +: PW];
                    if (lane_q[j].rs2 == lane_q[k].rd) nxt_rs2[j*PW +: PW] = rt_phys_rd_i[k*PW +: PW];
                    if (lane_q[j].rd  == lane_q[k].rd) nxt_old[j*PW +: PW] = rt_phys_rd_i[k*PW +: PW];
                end
            end
        end
`endif
        for (int j = 0; j < IW; j++) begin
            if (!slice_mask[j]) begin
                nxt_rs1[j*PW +: PW] = '0;
                nxt_rs2[j*PW +: PW] = '0;
                nxt_rd[j*PW +: PW]  = '0;
                nxt_old[j*PW +: PW] = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            for (int i = 0; i < IW; i++) lane_d[i].valid = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grp_valid_i) begin
                        for (int i = 0; i < IW; i++) begin
                            lane_d[i].rs1   = grp_rs1_i[i*AW +: AW];
                            lane_d[i].rs2   = grp_rs2_i[i*AW +: AW];
                            lane_d[i].rd    = grp_rd_i[i*AW +: AW];
                            lane_d[i].valid = grp_lane_valid_i[i];
                        end
                        state_d = (grp_lane_valid_i != '0) ? ST_RENAME : ST_IDLE;
                    end
                end
                default: begin
                    if (issue) begin
                        for (int i = 0; i < IW; i++) begin
                            if (slice_mask[i]) lane_d[i].valid = 1'b0;
                        end
                        state_d = ((pending & ~slice_mask) == '0) ? ST_IDLE : ST_RENAME;
                    end else if (lowest_alloc && free_zero) begin
                        state_d = ST_STALL;
                    end else begin
                        state_d = ST_RENAME;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            lane_q      <= '{default: '0};
            out_valid_q <= 1'b0;
            out_lane_q  <= '0;
            out_rs1_q   <= '0;
            out_rs2_q   <= '0;
            out_rd_q    <= '0;
            out_old_q   <= '0;
            stall_q     <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            if (flush_i) begin
                out_valid_q <= 1'b0;
                out_lane_q  <= '0;
            end else if (issue) begin
                out_valid_q <= 1'b1;
                out_lane_q  <= slice_mask;
                out_rs1_q   <= nxt_rs1;
                out_rs2_q   <= nxt_rs2;
                out_rd_q    <= nxt_rd;
                out_old_q   <= nxt_old;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
                out_lane_q  <= '0;
            end
            if (stall_inc && stall_q != {STALL_W{1'b1}}) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign out_valid_o       = out_valid_q;
    assign out_lane_valid_o  = out_lane_q;
    assign out_phys_rs1_o    = out_rs1_q;
    assign out_phys_rs2_o    = out_rs2_q;
    assign out_phys_rd_o     = out_rd_q;
    assign out_old_phys_rd_o = out_old_q;
    assign stall_cycles_o    = stall_q;

    a_slice_ready: assert property (@(posedge clk_i) disable iff (rst_i)
        ((rt_rename_valid_o & ~rt_rename_ready_i) == '0));
    a_slice_fits: assert property (@(posedge clk_i) disable iff (rst_i)
        (issue |-> (alloc_cnt <= rt_free_count_i)));

endmodule

// File: tb/tb_rename_dispatch_ctrl.sv
// Bench for rename_dispatch_ctrl: directed scenarios plus random traffic against a group/slice model.
// Expected forwarding follows RENAME_BYPASS_EN when it is defined for the build.
module tb_rename_dispatch_ctrl;

  localparam int IW = 4;
  localparam int PW = 6;
  localparam int AW = 5;

  logic clk_i = 1'b0;
  logic rst_i;
  logic flush_i, grp_valid_i, grp_ready_o, out_valid_o, out_ready_i;
  logic [IW-1:0] grp_lane_valid_i, rt_rename_valid_o, rt_rename_ready_i, out_lane_valid_o;
  logic [IW*AW-1:0] grp_rs1_i, grp_rs2_i, grp_rd_i, rt_arch_rs1_o, rt_arch_rs2_o, rt_arch_rd_o;
  logic [IW*PW-1:0] rt_phys_rs1_i, rt_phys_rs2_i, rt_phys_rd_i, rt_old_phys_rd_i;
  logic [IW*PW-1:0] out_phys_rs1_o, out_phys_rs2_o, out_phys_rd_o, out_old_phys_rd_o;
  logic [PW:0] rt_free_count_i;
  logic [15:0] stall_cycles_o;

  always #5 clk_i = ~clk_i;

  rename_dispatch_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .grp_valid_i(grp_valid_i), .grp_ready_o(grp_ready_o), .grp_lane_valid_i(grp_lane_valid_i),
    .grp_rs1_i(grp_rs1_i), .grp_rs2_i(grp_rs2_i), .grp_rd_i(grp_rd_i),
    .rt_rename_valid_o(rt_rename_valid_o), .rt_arch_rs1_o(rt_arch_rs1_o),
    .rt_arch_rs2_o(rt_arch_rs2_o), .rt_arch_rd_o(rt_arch_rd_o),
    .rt_rename_ready_i(rt_rename_ready_i), .rt_phys_rs1_i(rt_phys_rs1_i),
    .rt_phys_rs2_i(rt_phys_rs2_i), .rt_phys_rd_i(rt_phys_rd_i),
    .rt_old_phys_rd_i(rt_old_phys_rd_i), .rt_free_count_i(rt_free_count_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_lane_valid_o(out_lane_valid_o),
    .out_phys_rs1_o(out_phys_rs1_o), .out_phys_rs2_o(out_phys_rs2_o),
    .out_phys_rd_o(out_phys_rd_o), .out_old_phys_rd_o(out_old_phys_rd_o),
    .stall_cycles_o(stall_cycles_o)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: 0 = waiting for a group, 1 = renaming, 2 = stalled on an empty free list.
  int       m_mode = 0;
  bit [3:0] m_pend = '0;
  bit [4:0] m_rs1[4], m_rs2[4], m_rd[4];
  bit       e_valid = 1'b0;
  bit [3:0] e_lane = '0;
  bit [5:0] e_prs1[4], e_prs2[4], e_prd[4], e_pold[4];
  int       e_stall = 0;
  bit [5:0] d_prs1[4], d_prs2[4], d_prd[4], d_pold[4];
  bit [3:0] rv_seen;
  bit       rdy_seen;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // In-order walk over pending lanes, tracking registers written earlier in the slice.
  function automatic bit [3:0] ref_slice(input bit [3:0] pend, input int free);
    bit [4:0] written[$];
    int used;
    bit hit;
    ref_slice = '0;
    used = 0;
    for (int j = 0; j < 4; j++) begin
      if (!pend[j]) continue;
      hit = 1'b0;
`ifndef RENAME_BYPASS_EN
      foreach (written[w])
        if (written[w] == m_rs1[j] || written[w] == m_rs2[j] || written[w] == m_rd[j]) hit = 1'b1;
`endif
      if (hit || (used + int'(m_rd[j] != 0)) > free) break;
      ref_slice[j] = 1'b1;
      used += int'(m_rd[j] != 0);
      if (m_rd[j] != 0) written.push_back(m_rd[j]);
    end
  endfunction

`ifdef RENAME_BYPASS_EN
  function automatic int nearest_writer(input int j, input bit [4:0] r, input bit [3:0] mask);
    for (int k = j - 1; k >= 0; k--)
      if (mask[k] && m_rd[k] != 0 && m_rd[k] == r) return k;
    return -1;
  endfunction
`endif

  task automatic check_regs();
    check_eq("out_valid", out_valid_o, e_valid);
    check_eq("stall_cycles", stall_cycles_o, e_stall);
    if (e_valid) begin
      check_eq("out_lane_valid", out_lane_valid_o, e_lane);
      for (int j = 0; j < 4; j++) begin
        if (e_lane[j]) begin
          check_eq("out_phys_rs1", out_phys_rs1_o[j*PW +: PW], e_prs1[j]);
          check_eq("out_phys_rs2", out_phys_rs2_o[j*PW +: PW], e_prs2[j]);
          check_eq("out_phys_rd", out_phys_rd_o[j*PW +: PW], e_prd[j]);
          check_eq("out_old_phys_rd", out_old_phys_rd_o[j*PW +: PW], e_pold[j]);
        end
      end
    end
  endtask

  // One clock: drive inputs, check combinational outputs, advance the model, check registers.
  task automatic step(input bit fl, input bit gv, input bit [3:0] lv, input bit [19:0] rs1,
                      input bit [19:0] rs2, input bit [19:0] rd, input int free, input bit ordy);
    bit [3:0] sl, e_rv;
    bit e_rdy, la, found;
    int w;
    flush_i = fl; grp_valid_i = gv; grp_lane_valid_i = lv;
    grp_rs1_i = rs1; grp_rs2_i = rs2; grp_rd_i = rd;
    rt_free_count_i = 7'(free); out_ready_i = ordy;
    for (int j = 0; j < 4; j++) begin
      d_prs1[j] = 6'($urandom); d_prs2[j] = 6'($urandom);
      d_prd[j] = 6'($urandom); d_pold[j] = 6'($urandom);
      rt_phys_rs1_i[j*PW +: PW] = d_prs1[j]; rt_phys_rs2_i[j*PW +: PW] = d_prs2[j];
      rt_phys_rd_i[j*PW +: PW] = d_prd[j]; rt_old_phys_rd_i[j*PW +: PW] = d_pold[j];
    end
    #1;
    e_rdy = (m_mode == 0) && !fl;
    sl = ref_slice(m_pend, free);
    e_rv = (!fl && (m_mode == 1 || (m_mode == 2 && free > 0)) && (!e_valid || ordy)) ? sl : 4'b0;
    check_eq("grp_ready", grp_ready_o, e_rdy);
    check_eq("rename_valid", rt_rename_valid_o, e_rv);
    if (e_rv != 0) begin
      check_eq("arch_rd", rt_arch_rd_o, {m_rd[3], m_rd[2], m_rd[1], m_rd[0]});
      check_eq("arch_rs1", rt_arch_rs1_o, {m_rs1[3], m_rs1[2], m_rs1[1], m_rs1[0]});
    end
    rv_seen = rt_rename_valid_o;
    rdy_seen = grp_ready_o;
    if (m_mode == 2 || (m_mode == 1 && e_valid && !ordy))
      if (e_stall < 65535) e_stall++;
    la = 1'b0; found = 1'b0;
    for (int j = 0; j < 4; j++)
      if (m_pend[j] && !found) begin found = 1'b1; la = (m_rd[j] != 0); end
    if (fl) begin
      m_mode = 0; m_pend = '0; e_valid = 1'b0;
    end else if (e_rv != 0) begin
      e_valid = 1'b1; e_lane = e_rv;
      for (int j = 0; j < 4; j++) begin
        e_prs1[j] = d_prs1[j]; e_prs2[j] = d_prs2[j]; e_prd[j] = d_prd[j]; e_pold[j] = d_pold[j];
`ifdef RENAME_BYPASS_EN
        w = nearest_writer(j, m_rs1[j], e_rv); if (w >= 0) e_prs1[j] = d_prd[w];
        w = nearest_writer(j, m_rs2[j], e_rv); if (w >= 0) e_prs2[j] = d_prd[w];
        w = nearest_writer(j, m_rd[j], e_rv);  if (w >= 0) e_pold[j] = d_prd[w];
`else
        w = 0;
`endif
      end
      m_pend &= ~e_rv;
      m_mode = (m_pend != 0) ? 1 : 0;
    end else begin
      if (ordy) e_valid = 1'b0;
      if (m_mode == 0) begin
        if (gv) begin
          for (int j = 0; j < 4; j++) begin
            m_rs1[j] = rs1[j*AW +: AW]; m_rs2[j] = rs2[j*AW +: AW]; m_rd[j] = rd[j*AW +: AW];
          end
          m_pend = lv;
          m_mode = (lv != 0) ? 1 : 0;
        end
      end else begin
        m_mode = (la && free == 0) ? 2 : 1;
      end
    end
    @(posedge clk_i); #1;
    check_regs();
  endtask

  task automatic idle(input int free, input bit ordy);
    step(1'b0, 1'b0, 4'b0, 20'b0, 20'b0, 20'b0, free, ordy);
  endtask

  initial begin
    bit [23:0] held;
    bit [3:0] rv_or;
    int base;
    bit [19:0] r1, r2, rd;
    int fr, r;
    rst_i = 1'b1; flush_i = 1'b0; grp_valid_i = 1'b0; grp_lane_valid_i = '0;
    grp_rs1_i = '0; grp_rs2_i = '0; grp_rd_i = '0; rt_rename_ready_i = '1;
    rt_phys_rs1_i = '0; rt_phys_rs2_i = '0; rt_phys_rd_i = '0; rt_old_phys_rd_i = '0;
    rt_free_count_i = '0; out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_out_valid", out_valid_o, 0);
    check_eq("rst_lane_valid", out_lane_valid_o, 0);
    check_eq("rst_out_rd", out_phys_rd_o, 0);
    check_eq("rst_out_rs1", out_phys_rs1_o, 0);
    check_eq("rst_stall", stall_cycles_o, 0);
    check_eq("rst_rename_valid", rt_rename_valid_o, 0);
    rst_i = 1'b0;
    #1;
    check_eq("rst_grp_ready", grp_ready_o, 1);

    // Independent group: one full slice, output two cycles after acceptance.
    step(1'b0, 1'b1, 4'hF, 20'b0, 20'b0, {5'd4, 5'd3, 5'd2, 5'd1}, 32, 1'b1);
    idle(32, 1'b1);
    check_eq("t1_slice", rv_seen, 4'b1111);
    check_eq("t1_latency", out_valid_o, 1);
    check_eq("t1_prd", out_phys_rd_o, {d_prd[3], d_prd[2], d_prd[1], d_prd[0]});

    // Free-list limit, stall, then resume including the non-allocating lane.
    step(1'b0, 1'b1, 4'hF, 20'b0, 20'b0, {5'd0, 5'd7, 5'd6, 5'd5}, 32, 1'b1);
    idle(2, 1'b1);
    check_eq("t2_slice0", rv_seen, 4'b0011);
    idle(0, 1'b1);
    check_eq("t2_stall_req", rv_seen, 4'b0000);
    idle(0, 1'b1);
    idle(1, 1'b1);
    check_eq("t2_slice1", rv_seen, 4'b1100);
    check_eq("t2_idle", grp_ready_o, 1);

    // Lane1 reads lane0's rd; lane2 rewrites lane0's rd.
    step(1'b0, 1'b1, 4'hF, {5'd0, 5'd0, 5'd7, 5'd0}, 20'b0, {5'd10, 5'd7, 5'd8, 5'd7}, 32, 1'b1);
    idle(32, 1'b1);
`ifdef RENAME_BYPASS_EN
    check_eq("t3_slice", rv_seen, 4'b1111);
    check_eq("t3_fwd_rs1", out_phys_rs1_o[11:6], d_prd[0]);
    check_eq("t3_fwd_old", out_old_phys_rd_o[17:12], d_prd[0]);
`else
    check_eq("t3_slice0", rv_seen, 4'b0001);
    idle(32, 1'b1);
    check_eq("t3_slice1", rv_seen, 4'b1110);
`endif

    // Backpressure: output held, no requests, stall counter advances once per blocked cycle.
    step(1'b0, 1'b1, 4'hF, 20'b0, 20'b0, {5'd4, 5'd3, 5'd2, 5'd1}, 32, 1'b1);
    idle(32, 1'b1);
    held = {d_prd[3], d_prd[2], d_prd[1], d_prd[0]};
    step(1'b0, 1'b1, 4'hF, 20'b0, 20'b0, {5'd8, 5'd7, 5'd6, 5'd5}, 32, 1'b0);
    base = e_stall;
    rv_or = '0;
    repeat (5) begin
      idle(32, 1'b0);
      rv_or |= rv_seen;
    end
    check_eq("t4_no_req", rv_or, 0);
    check_eq("t4_stall", stall_cycles_o, base + 5);
    check_eq("t4_hold", out_phys_rd_o, held);
    idle(32, 1'b1);
    check_eq("t4_release", rv_seen, 4'b1111);

    // Flush while lanes 2 and 3 are still pending.
    step(1'b0, 1'b1, 4'hF, 20'b0, 20'b0, {5'd6, 5'd5, 5'd0, 5'd3}, 32, 1'b1);
    idle(1, 1'b1);
    check_eq("t5_first", rv_seen, 4'b0011);
    step(1'b1, 1'b0, 4'b0, 20'b0, 20'b0, 20'b0, 32, 1'b1);
    check_eq("t5_rv", rv_seen, 0);
    check_eq("t5_outv", out_valid_o, 0);
    idle(32, 1'b1);
    check_eq("t5_ready", rdy_seen, 1);

    // Random traffic with narrow register range to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      for (int j = 0; j < 4; j++) begin
        r1[j*AW +: AW] = 5'($urandom_range(0, 7));
        r2[j*AW +: AW] = 5'($urandom_range(0, 7));
        rd[j*AW +: AW] = 5'($urandom_range(0, 7));
      end
      r = $urandom_range(0, 9);
      fr = (r < 3) ? 0 : (r == 9 ? 64 : r - 2);
      step($urandom_range(0, 31) == 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           r1, r2, rd, fr, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
